// File: rtl/dff_mem2_pkg.sv
// Shared types and constants for the tt_um_dff_mem2 flop-based scratch memory.
package dff_mem2_pkg;

  localparam int unsigned MIN_RAM_BYTES = 4;
  localparam int unsigned MAX_RAM_BYTES = 16;

  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpWrite = 2'b01,
    OpRead  = 2'b10,
    OpPtr   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ModeDirect = 2'b00,
    ModeAuto   = 2'b01,
    ModeFifo   = 2'b10
  } mode_e;

  // Encoding 11 aliases DIRECT; 10 is DIRECT too when the FIFO is not built.
  function automatic mode_e decode_mode(input logic [1:0] sel, input bit fifo_en);
    case (sel)
      2'b01:   return ModeAuto;
      2'b10:   return fifo_en ? ModeFifo : ModeDirect;
      default: return ModeDirect;
    endcase
  endfunction

endpackage

// File: rtl/dff_mem2_fifo_ctrl.sv
// FIFO pointer/occupancy tracker with sticky overflow/underflow error flag.
// Exposes next-state status so the top can register post-update flags.
module dff_mem2_fifo_ctrl
  import dff_mem2_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 16,
  localparam int unsigned AW = $clog2(RAM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          push_ok,
  output logic          pop_ok,
  output logic [AW:0]   count_nxt,
  output logic          err_nxt,
  output logic          full_nxt,
  output logic          empty_nxt
);

  localparam logic [AW:0] FullCount = (AW + 1)'(RAM_BYTES);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          full, empty;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign count_nxt = count_d;
  assign err_nxt   = err_d;
  assign full_nxt  = (count_d == FullCount);
  assign empty_nxt = (count_d == '0);

endmodule

// File: rtl/tt_um_dff_mem2.sv
// Flop-based byte memory with DIRECT / AUTO-increment / optional FIFO addressing.
// Define DFF_MEM_FIFO_EN to build FIFO mode (ui_in[5:4] = 10).
module tt_um_dff_mem2
  import dff_mem2_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int unsigned AW = $clog2(RAM_BYTES);

`ifdef DFF_MEM_FIFO_EN
  localparam bit FifoEn = 1'b1;
`else
  localparam bit FifoEn = 1'b0;
`endif

  op_e           op;
  mode_e         mode;
  logic [AW-1:0] addr;
  logic          wr_drop;

  logic [7:0]    mem_q [RAM_BYTES];
  logic [AW-1:0] ap_q, ap_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    uio_out_q, uio_out_d;
  logic [7:0]    uo_out_q, uo_out_d;

  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;

  assign op      = ena ? op_e'(ui_in[7:6]) : OpIdle;
  assign mode    = decode_mode(ui_in[5:4], FifoEn);
  assign addr    = ui_in[AW-1:0];
  // A write landing while the bus is still turned around for read data is dropped.
  assign wr_drop = (op == OpWrite) && rd_valid_q;

`ifdef DFF_MEM_FIFO_EN
  logic          push, pop, clr;
  logic          push_ok, pop_ok;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          err_nxt, full_nxt, empty_nxt;

  assign push = (mode == ModeFifo) && (op == OpWrite) && !wr_drop;
  assign pop  = (mode == ModeFifo) && (op == OpRead);
  assign clr  = (mode == ModeFifo) && (op == OpPtr);

  dff_mem2_fifo_ctrl #(
    .RAM_BYTES(RAM_BYTES)
  ) u_fifo_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (clr),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .count_nxt (count_nxt),
    .err_nxt   (err_nxt),
    .full_nxt  (full_nxt),
    .empty_nxt (empty_nxt)
  );
`endif

  always_comb begin
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = addr;
    rd_addr = addr;
    ap_d    = ap_q;
    case (mode)
      ModeAuto: begin
        wr_addr = ap_q;
        rd_addr = ap_q;
        if (op == OpWrite && !wr_drop) begin
          wr_en = 1'b1;
          ap_d  = ap_q + 1'b1;
        end else if (op == OpRead) begin
          rd_en = 1'b1;
          ap_d  = ap_q + 1'b1;
        end else if (op == OpPtr) begin
          ap_d = addr;
        end
      end
`ifdef DFF_MEM_FIFO_EN
      ModeFifo: begin
        wr_en   = push_ok;
        wr_addr = wr_ptr;
        rd_en   = pop_ok;
        rd_addr = rd_ptr;
      end
`endif
      default: begin
        wr_en = (op == OpWrite) && !wr_drop;
        rd_en = (op == OpRead);
        if (op == OpPtr) ap_d = addr;
      end
    endcase
  end

  always_comb begin
    rd_valid_d = rd_valid_q;
    uio_out_d  = uio_out_q;
    if (op == OpWrite || op == OpPtr) rd_valid_d = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      uio_out_d  = mem_q[rd_addr];
    end
  end

  always_comb begin
    uo_out_d = {3'b000, 5'(ap_d)};
`ifdef DFF_MEM_FIFO_EN
    if (mode == ModeFifo) begin
      uo_out_d = {empty_nxt, full_nxt, err_nxt, 5'(count_nxt)};
    end else begin
      uo_out_d = {2'b00, err_nxt, 5'(ap_d)};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      ap_q       <= '0;
      rd_valid_q <= 1'b0;
      uio_out_q  <= '0;
      uo_out_q   <= '0;
    end else begin
      if (wr_en) mem_q[wr_addr] <= uio_in;
      ap_q       <= ap_d;
      rd_valid_q <= rd_valid_d;
      uio_out_q  <= uio_out_d;
      uo_out_q   <= uo_out_d;
    end
  end

  assign uio_out = uio_out_q;
  assign uio_oe  = {8{rd_valid_q}};
  assign uo_out  = uo_out_q;

endmodule

// File: tb/tb_tt_um_dff_mem2.sv
// Directed bench for tt_um_dff_mem2 (RAM_BYTES=16); FIFO steps only when DFF_MEM_FIFO_EN is set.
module tb_tt_um_dff_mem2;

  localparam logic [1:0] OP_IDLE = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_PTR = 2'b11;
  localparam logic [1:0] M_DIR = 2'b00, M_AUTO = 2'b01, M_FIFO = 2'b10, M_DIR11 = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;

  tt_um_dff_mem2 #(
    .RAM_BYTES(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one op, then sample 1 time unit after the edge that consumed it.
  task automatic drive(input logic [1:0] op, input logic [1:0] mode, input logic [3:0] addr,
                       input logic [7:0] data);
    ui_in  = {op, mode, addr};
    uio_in = data;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;

    // Reset edge with a write pending: the write must be discarded.
    drive(OP_WR, M_DIR, 4'd3, 8'hFF);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    drive(OP_IDLE, M_DIR, 4'd0, 8'h00);
    check("post_rst_uo_out", uo_out, 8'h00);
    check("post_rst_uio_oe", uio_oe, 8'h00);

    // DIRECT write / idle / read.
    drive(OP_WR, M_DIR, 4'd3, 8'hA5);
    check("dir_wr_oe", uio_oe, 8'h00);
    drive(OP_IDLE, M_DIR, 4'd0, 8'h00);
    check("dir_idle_oe", uio_oe, 8'h00);
    drive(OP_RD, M_DIR, 4'd3, 8'h00);
    check("dir_rd_data", uio_out, 8'hA5);
    check("dir_rd_oe", uio_oe, 8'hFF);
    drive(OP_RD, M_DIR, 4'd5, 8'h00);
    check("dir_rd_cleared", uio_out, 8'h00);
    drive(OP_IDLE, M_DIR, 4'd0, 8'h00);
    check("rd_valid_hold_oe", uio_oe, 8'hFF);

    // Turnaround: write while rd_valid is dropped, reissue stores.
    drive(OP_WR, M_DIR, 4'd7, 8'h5A);
    check("turn_drop_oe", uio_oe, 8'h00);
    check("turn_drop_uio_out", uio_out, 8'h00);
    drive(OP_RD, M_DIR, 4'd7, 8'h00);
    check("turn_dropped_mem", uio_out, 8'h00);
    drive(OP_PTR, M_DIR, 4'd0, 8'h00);
    drive(OP_WR, M_DIR, 4'd7, 8'h5A);
    drive(OP_RD, M_DIR, 4'd7, 8'h00);
    check("turn_reissue", uio_out, 8'h5A);

    // AUTO with pointer wrap 15 -> 0.
    drive(OP_PTR, M_AUTO, 4'd15, 8'h00);
    check("auto_ptr_uo", uo_out, 8'h0F);
    check("auto_ptr_oe", uio_oe, 8'h00);
    drive(OP_WR, M_AUTO, 4'd9, 8'h11);
    check("auto_wr1_uo", uo_out, 8'h00);
    drive(OP_WR, M_AUTO, 4'd9, 8'h22);
    check("auto_wr2_uo", uo_out, 8'h01);
    drive(OP_RD, M_DIR, 4'd15, 8'h00);
    check("auto_ram15", uio_out, 8'h11);
    check("mode_chg_ap", uo_out, 8'h01);
    drive(OP_RD, M_DIR11, 4'd0, 8'h00);
    check("auto_ram0_mode11", uio_out, 8'h22);
    drive(OP_PTR, M_AUTO, 4'd15, 8'h00);
    drive(OP_RD, M_AUTO, 4'd0, 8'h00);
    check("auto_rd1_data", uio_out, 8'h11);
    check("auto_rd1_uo", uo_out, 8'h00);
    drive(OP_RD, M_AUTO, 4'd0, 8'h00);
    check("auto_rd2_data", uio_out, 8'h22);
    check("auto_rd2_uo", uo_out, 8'h01);

    // ena=0 turns a write into IDLE.
    ena = 1'b0;
    drive(OP_WR, M_DIR, 4'd9, 8'h33);
    check("ena0_oe_hold", uio_oe, 8'hFF);
    ena = 1'b1;
    drive(OP_RD, M_DIR, 4'd9, 8'h00);
    check("ena0_no_write", uio_out, 8'h00);

`ifndef DFF_MEM_FIFO_EN
    // Mode 10 without the FIFO behaves as DIRECT.
    drive(OP_PTR, M_DIR, 4'd0, 8'h00);
    drive(OP_WR, M_FIFO, 4'd2, 8'h7E);
    check("m10_uo", uo_out, 8'h00);
    drive(OP_RD, M_DIR, 4'd2, 8'h00);
    check("m10_ram2", uio_out, 8'h7E);
    drive(OP_PTR, M_FIFO, 4'd6, 8'h00);
    check("m10_ptr_uo", uo_out, 8'h06);
`else
    drive(OP_IDLE, M_FIFO, 4'd0, 8'h00);
    check("fifo_empty_uo", uo_out, 8'h80);
    drive(OP_PTR, M_FIFO, 4'd0, 8'h00);
    for (int i = 0; i < 16; i++) drive(OP_WR, M_FIFO, 4'd0, 8'(i));
    check("fifo_full_uo", uo_out, 8'h50);
    drive(OP_WR, M_FIFO, 4'd0, 8'h99);
    check("fifo_ovf_uo", uo_out, 8'h70);
    for (int i = 0; i < 16; i++) begin
      drive(OP_RD, M_FIFO, 4'd0, 8'h00);
      check("fifo_pop_data", uio_out, 8'(i));
    end
    check("fifo_drained_uo", uo_out, 8'hA0);
    drive(OP_RD, M_FIFO, 4'd0, 8'h00);
    check("fifo_udf_data", uio_out, 8'h0F);
    check("fifo_udf_uo", uo_out, 8'hA0);
    drive(OP_PTR, M_FIFO, 4'd0, 8'h00);
    check("fifo_clr_uo", uo_out, 8'h80);
    for (int i = 0; i < 5; i++) drive(OP_WR, M_FIFO, 4'd0, 8'(i + 8'h40));
    check("fifo_cnt5_uo", uo_out, 8'h05);
    rst_n = 1'b0;
    drive(OP_WR, M_FIFO, 4'd0, 8'hEE);
    rst_n = 1'b1;
    check("fifo_rst_uo", uo_out, 8'h00);
    drive(OP_IDLE, M_FIFO, 4'd0, 8'h00);
    check("fifo_post_rst_uo", uo_out, 8'h80);
    check("fifo_post_rst_oe", uio_oe, 8'h00);
    drive(OP_RD, M_DIR, 4'd1, 8'h00);
    check("fifo_rst_ram1", uio_out, 8'h00);
`endif

    // Reset clears memory written earlier.
    rst_n = 1'b0;
    drive(OP_IDLE, M_DIR, 4'd0, 8'h00);
    rst_n = 1'b1;
    check("rst2_oe", uio_oe, 8'h00);
    drive(OP_RD, M_DIR, 4'd7, 8'h00);
    check("rst2_ram7", uio_out, 8'h00);
    check("rst2_uo", uo_out, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
